// File: rtl/pci_pkg.sv
// Shared PCI definitions: arbiter states, bus command codes and the device
// address map used by both the arbiter and the bus devices.
package pci_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANTED    = 2'd1,
    BUSY       = 2'd2,
    TURNAROUND = 2'd3
  } arb_state_e;

  localparam logic [3:0] CBE_WRITE = 4'b0011;
  localparam logic [3:0] CBE_READ  = 4'b0010;

  localparam logic [31:0] ADDR_DEV_A = 32'h0000_00AD;
  localparam logic [31:0] ADDR_DEV_B = 32'h0000_00BD;
  localparam logic [31:0] ADDR_DEV_C = 32'h0000_00CD;

endpackage

// File: rtl/pci_rr_picker.sv
// Combinational round-robin search: first active-low request strictly after
// the last-served index, wrapping around.
module pci_rr_picker #(
  parameter int NUM_MASTERS = 3,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_n_i,
  input  logic [IDX_W-1:0]       last_i,
  output logic                   found_o,
  output logic [IDX_W-1:0]       idx_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             hit;

  always_comb begin
    hit      = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    // Offsets 1..NUM_MASTERS so the last-served master is tried last.
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand     = (int'(last_i) + k) % NUM_MASTERS;
      cand_idx = IDX_W'(cand);
      if (!hit && !req_n_i[cand_idx]) begin
        hit   = 1'b1;
        idx_o = cand_idx;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/pci_arbiter.sv
// Central round-robin PCI arbiter: one active-low GNT at a time, handed out
// only on an idle bus, with a turnaround cycle between consecutive grants.
module pci_arbiter
  import pci_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int GNT_TIMEOUT = 16,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] REQ,
  output logic [NUM_MASTERS-1:0] GNT,
  input  logic                   FRAME,
  input  logic                   IRDY,
  output logic [IDX_W-1:0]       owner,
  output logic                   grant_active,
  output logic                   timeout_pulse
);

  localparam int               TMR_W     = $clog2(GNT_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(GNT_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_MASTERS - 1);

  arb_state_e             state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic                   tmo_q, tmo_d;

  logic                   bus_idle;
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic                   grant_now, release_now, timeout_now;

  assign bus_idle = FRAME & IRDY;

  pci_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req_n_i(REQ),
    .last_i (last_q),
    .found_o(pick_found),
    .idx_o  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      last_q  <= LAST_INIT;
      owner_q <= '0;
      gnt_q   <= '1;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_now   = 1'b0;
    release_now = 1'b0;
    timeout_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_idle && pick_found) begin
          grant_now = 1'b1;
          state_d   = GRANTED;
        end
      end
      GRANTED: begin
        // FRAME falling wins over a same-cycle request drop or timeout.
        if (!FRAME) begin
          state_d = BUSY;
        end else if (REQ[owner_q]) begin
          release_now = 1'b1;
          state_d     = TURNAROUND;
        end else if (timer_q == TMR_LAST) begin
          release_now = 1'b1;
          timeout_now = 1'b1;
          state_d     = TURNAROUND;
        end
      end
      BUSY: begin
        if (bus_idle) begin
          release_now = 1'b1;
          state_d     = TURNAROUND;
        end
      end
      TURNAROUND: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    timer_d = timer_q;
    tmo_d   = timeout_now;
    if (grant_now) begin
      gnt_d   = ~(NUM_MASTERS'(1) << pick_idx);
      owner_d = pick_idx;
      timer_d = '0;
    end else if (release_now) begin
      gnt_d  = '1;
      last_d = owner_q;
    end else if (state_q == GRANTED && timer_q != TMR_LAST) begin
      timer_d = timer_q + 1'b1;
    end
  end

  assign GNT           = gnt_q;
  assign owner         = owner_q;
  assign grant_active  = ~&gnt_q;
  assign timeout_pulse = tmo_q;

endmodule
